// File: rtl/bfm_apbslave_mem_if.sv
// APB3 bus bundle between one bridge PSEL bit and the slave memory model.
//   PSEL, PADDR, PWRITE, PENABLE, PWDATA : master -> slave request signals
//   PRDATA, PREADY, PSLVERR              : slave -> master response signals
//   PROTERR                              : slave sticky protocol-violation flag
//   dbg_state                            : slave FSM state (0 = IDLE, 1 = ACCESS)
// Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by one or
// more access cycles (PSEL=1, PENABLE=1); it completes on the rising edge
// where PREADY=1 is sampled together with PENABLE=1. PADDR/PWRITE/PWDATA must
// hold from setup until completion.
interface bfm_apbslave_mem_if;
  logic        PSEL;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        PROTERR;
  logic        dbg_state;

  modport slave (
    input  PSEL, PADDR, PWRITE, PENABLE, PWDATA,
    output PRDATA, PREADY, PSLVERR, PROTERR, dbg_state
  );

  modport master (
    output PSEL, PADDR, PWRITE, PENABLE, PWDATA,
    input  PRDATA, PREADY, PSLVERR, PROTERR, dbg_state
  );
endinterface

// File: rtl/bfm_apbslave_mem.sv
// APB3 slave memory model: word-addressed 32-bit memory of 2^AWIDTH words with
// a programmable number of access-phase wait states, PSLVERR for out-of-range
// addresses and a sticky PROTERR flag for master handshake violations.
// Ports:
//   PCLK   : clock, all logic on the rising edge
//   PRESET : synchronous active-high reset (memory contents are kept)
//   apb    : bfm_apbslave_mem_if.slave bus bundle
// Parameters: AWIDTH (word-address bits), WAITS (0..15 wait states).
// Optional macro BFM_APBSLV_LFSR_WAIT_EN: per-transfer wait count becomes
// lfsr[3:0] % (WAITS+1) from an 8-bit LFSR seeded to 8'hA5 on reset.
module bfm_apbslave_mem #(
  parameter int AWIDTH = 8,
  parameter int WAITS  = 0
) (
  input  logic               PCLK,
  input  logic               PRESET,
  bfm_apbslave_mem_if.slave  apb
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        proterr_q, proterr_d;
  logic        mem_we;
  logic [3:0]  w_val;
  logic        oor;

  // Zero at time 0; deliberately untouched by PRESET.
  logic [31:0] mem_q [0:(1<<AWIDTH)-1] = '{default: '0};

  assign oor = |apb.PADDR[31:AWIDTH+2];

`ifdef BFM_APBSLV_LFSR_WAIT_EN
  logic [7:0] lfsr_q, lfsr_d;
  // x^8+x^6+x^5+x^4+1 Fibonacci, shifting towards the MSB.
  logic [7:0] lfsr_next;
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign w_val = 4'(5'(lfsr_q[3:0]) % 5'(WAITS + 1));
`else
  assign w_val = 4'(WAITS);
`endif

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    proterr_d = proterr_q;
    mem_we    = 1'b0;
`ifdef BFM_APBSLV_LFSR_WAIT_EN
    lfsr_d    = lfsr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          paddr_d  = apb.PADDR;
          pwrite_d = apb.PWRITE;
          cnt_d    = w_val;
          ready_d  = (w_val == 4'd0);
          err_d    = oor;
          // Read data is fetched at setup; it cannot change before completion
          // because the only writer is this same transfer.
          rdata_d  = oor ? 32'h0 : mem_q[apb.PADDR[AWIDTH+1:2]];
          state_d  = S_ACCESS;
`ifdef BFM_APBSLV_LFSR_WAIT_EN
          lfsr_d   = lfsr_next;
`endif
        end else if (apb.PSEL && apb.PENABLE) begin
          proterr_d = 1'b1;
        end
      end
      S_ACCESS: begin
        if (!apb.PSEL) begin
          proterr_d = 1'b1;
          ready_d   = 1'b0;
          err_d     = 1'b0;
          state_d   = S_IDLE;
        end else begin
          // Unstable request is flagged; the latched copy stays authoritative.
          if (apb.PADDR != paddr_q || apb.PWRITE != pwrite_q) proterr_d = 1'b1;
          if (ready_q && apb.PENABLE) begin
            mem_we  = pwrite_q & ~err_q;
            ready_d = 1'b0;
            err_d   = 1'b0;
            rdata_d = 32'h0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            ready_d = (cnt_q == 4'd1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      paddr_q   <= 32'h0;
      pwrite_q  <= 1'b0;
      cnt_q     <= 4'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      proterr_q <= 1'b0;
`ifdef BFM_APBSLV_LFSR_WAIT_EN
      lfsr_q    <= 8'hA5;
`endif
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      proterr_q <= proterr_d;
`ifdef BFM_APBSLV_LFSR_WAIT_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  // A reset landing on the completion edge suppresses the write.
  always_ff @(posedge PCLK) begin
    if (!PRESET && mem_we) mem_q[paddr_q[AWIDTH+1:2]] <= apb.PWDATA;
  end

  assign apb.PREADY    = ready_q;
  assign apb.PSLVERR   = ready_q & err_q;
  assign apb.PRDATA    = (ready_q && !err_q) ? rdata_q : 32'h0;
  assign apb.PROTERR   = proterr_q;
  assign apb.dbg_state = state_q;

endmodule
